demux_2b: RTL and testbench

DEMUX_2B -- requirements
Module: demux_2b

---
 rtl/demux_2b.sv | 82 ++++++++
 tb/tb_demux_2b.sv | 140 ++++++++++++++
 2 files changed

// File: rtl/demux_2b.sv
// Two-lane demux with a 2-entry FIFO per lane; lane chosen by selector.
// Define DEMUX_ALTERNATE_EN to alternate lanes per accepted word instead.
module demux_2b (
  input  logic       clok,
  input  logic       reset,
  input  logic       valid_in,
  input  logic [1:0] data_in,
  input  logic       selector,
  output logic       ready_in,
  output logic       valid_out0,
  output logic [1:0] data_out0,
  input  logic       ready_out0,
  output logic       valid_out1,
  output logic [1:0] data_out1,
  input  logic       ready_out1
);

  logic [1:0] mem [2][2];
  logic [1:0] cnt [2];
  logic       wp  [2];
  logic       rp  [2];
  logic       lane;
  logic       push;
  logic [1:0] hit;
  logic [1:0] pop;

`ifdef DEMUX_ALTERNATE_EN
  logic next_lane;
  logic unused_sel;

  assign unused_sel = selector;
  assign lane       = next_lane;

  always_ff @(posedge clok) begin
    if (reset)
      next_lane <= 1'b0;
    else if (push)
      next_lane <= ~next_lane;
  end
`else
  assign lane = selector;
`endif

  // Readiness looks only at registered occupancy, never at a same-cycle pop.
  assign ready_in = (cnt[lane] != 2'd2);
  assign push     = valid_in & ready_in;
  assign hit[0]   = push & ~lane;
  assign hit[1]   = push & lane;

  assign valid_out0 = (cnt[0] != 2'd0);
  assign valid_out1 = (cnt[1] != 2'd0);
  assign pop[0]     = valid_out0 & ready_out0;
  assign pop[1]     = valid_out1 & ready_out1;
  assign data_out0  = mem[0][rp[0]];
  assign data_out1  = mem[1][rp[1]];

  always_ff @(posedge clok) begin
    if (reset) begin
      for (int n = 0; n < 2; n++) begin
        cnt[n]    <= 2'd0;
        wp[n]     <= 1'b0;
        rp[n]     <= 1'b0;
        mem[n][0] <= 2'b00;
        mem[n][1] <= 2'b00;
      end
    end else begin
      for (int n = 0; n < 2; n++) begin
        if (hit[n]) begin
          mem[n][wp[n]] <= data_in;
          wp[n]         <= ~wp[n];
        end
        if (pop[n])
          rp[n] <= ~rp[n];
        if (hit[n] && !pop[n])
          cnt[n] <= cnt[n] + 2'd1;
        else if (!hit[n] && pop[n])
          cnt[n] <= cnt[n] - 2'd1;
      end
    end
  end

endmodule

// File: tb/tb_demux_2b.sv
// Randomised bench for demux_2b against a queue-based lane model.
// Directed sequences first, then random traffic with occasional resets.
module tb_demux_2b;

  logic       clok = 1'b0;
  logic       reset = 1'b1;
  logic       valid_in = 1'b0;
  logic [1:0] data_in = 2'b00;
  logic       selector = 1'b0;
  logic       ready_in;
  logic       valid_out0;
  logic [1:0] data_out0;
  logic       ready_out0 = 1'b0;
  logic       valid_out1;
  logic [1:0] data_out1;
  logic       ready_out1 = 1'b0;

  int total = 0;
  int bad   = 0;

  logic [1:0] q0 [$];
  logic [1:0] q1 [$];
  logic       nl = 1'b0;

  always #5 clok = ~clok;

  demux_2b dut (
    .clok       (clok),
    .reset      (reset),
    .valid_in   (valid_in),
    .data_in    (data_in),
    .selector   (selector),
    .ready_in   (ready_in),
    .valid_out0 (valid_out0),
    .data_out0  (data_out0),
    .ready_out0 (ready_out0),
    .valid_out1 (valid_out1),
    .data_out1  (data_out1),
    .ready_out1 (ready_out1)
  );

  task automatic chk(input string tag, input logic [1:0] got,
                     input logic [1:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%b exp=%b t=%0t", tag, got, exp, $time);
    end
  endtask

  // One cycle: check current state, drive inputs, advance the model.
  task automatic step(input logic v, input logic [1:0] d, input logic s,
                      input logic r0, input logic r1, input logic rs);
    logic t;
    logic rdy;
    logic p0;
    logic p1;
    @(negedge clok);
    chk("valid0", valid_out0, {1'b0, q0.size() != 0});
    chk("valid1", valid_out1, {1'b0, q1.size() != 0});
    if (q0.size() != 0) chk("data0", data_out0, q0[0]);
    if (q1.size() != 0) chk("data1", data_out1, q1[0]);
    valid_in   = v;
    data_in    = d;
    selector   = s;
    ready_out0 = r0;
    ready_out1 = r1;
    reset      = rs;
`ifdef DEMUX_ALTERNATE_EN
    t = nl;
`else
    t = s;
`endif
    rdy = t ? (q1.size() < 2) : (q0.size() < 2);
    #1;
    chk("ready_in", {1'b0, ready_in}, {1'b0, rdy});
    if (rs) begin
      q0.delete();
      q1.delete();
      nl = 1'b0;
    end else begin
      p0 = r0 && q0.size() != 0;
      p1 = r1 && q1.size() != 0;
      if (p0) void'(q0.pop_front());
      if (p1) void'(q1.pop_front());
      if (v && rdy) begin
        if (t) q1.push_back(d);
        else   q0.push_back(d);
        nl = ~nl;
      end
    end
  endtask

  initial begin
    step(0, 2'b00, 0, 0, 0, 1);
    step(0, 2'b00, 0, 0, 0, 1);
    step(0, 2'b00, 0, 0, 0, 0);
    chk("rst_data0", data_out0, 2'b00);
    chk("rst_data1", data_out1, 2'b00);
    chk("rst_rdy", {1'b0, ready_in}, 2'b01);

`ifdef DEMUX_ALTERNATE_EN
    step(1, 2'b00, 1, 1, 1, 0);
    step(1, 2'b01, 0, 1, 1, 0);
    step(1, 2'b10, 1, 1, 1, 0);
    step(1, 2'b11, 0, 1, 1, 0);
    step(0, 2'b00, 1, 1, 1, 0);
    step(0, 2'b00, 0, 1, 1, 0);
`else
    step(1, 2'b10, 1, 0, 0, 0);
    step(0, 2'b00, 0, 0, 0, 0);
    step(0, 2'b00, 0, 0, 1, 0);
    step(1, 2'b01, 0, 0, 0, 0);
    step(1, 2'b11, 0, 0, 0, 0);
    step(1, 2'b10, 0, 0, 0, 0);
    step(1, 2'b10, 0, 1, 0, 0);
    step(0, 2'b00, 0, 1, 0, 0);
    step(0, 2'b00, 0, 1, 0, 0);
`endif

    // Both lanes full, then a reset pulse and fresh traffic.
    for (int i = 0; i < 4; i++)
      step(1, 2'(i), 1'(i), 0, 0, 0);
    step(0, 2'b00, 0, 0, 0, 1);
    step(1, 2'b11, 0, 0, 0, 0);
    step(1, 2'b01, 1, 0, 0, 0);
    step(0, 2'b00, 0, 1, 1, 0);
    step(0, 2'b00, 0, 1, 1, 0);

    for (int i = 0; i < 3000; i++)
      step(1'($urandom_range(0, 3) != 0), 2'($urandom),
           1'($urandom), 1'($urandom), 1'($urandom),
           $urandom_range(0, 60) == 0);
    step(0, 2'b00, 0, 0, 0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
